// File: rtl/svpwm_update_ctrl.sv
// SVPWM period update scheduler: requests a T1/T2/sector calculation ahead of each
// period boundary, sanitises the result and commits it exactly at the wrap edge.
module svpwm_update_ctrl #(
   parameter int unsigned TIM_WIDTH  = 16,
   parameter int unsigned SEC_WIDTH  = 3,
   parameter int unsigned LEAD_CNT   = 64,
   parameter int unsigned MISS_LIMIT = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [TIM_WIDTH-1:0] t_period_cnt,
   output logic                 calc_req,
   input  logic                 calc_valid,
   input  logic [TIM_WIDTH-1:0] t1_calc,
   input  logic [TIM_WIDTH-1:0] t2_calc,
   input  logic [SEC_WIDTH-1:0] sector_calc,
   output logic [TIM_WIDTH-1:0] t1_out,
   output logic [TIM_WIDTH-1:0] t2_out,
   output logic [SEC_WIDTH-1:0] sector_out,
   output logic                 period_start,
   output logic                 upd_done,
   output logic [7:0]           miss_cnt,
   output logic                 fault,
   input  logic                 fault_clr
);

   localparam int unsigned          CW      = 8;
   localparam logic [TIM_WIDTH-1:0] T_MAX   = {1'b0, {(TIM_WIDTH-1){1'b1}}};
   localparam logic [TIM_WIDTH-1:0] LEAD    = TIM_WIDTH'(LEAD_CNT);
   localparam logic [SEC_WIDTH-1:0] SEC_MIN = SEC_WIDTH'(1);
   localparam logic [SEC_WIDTH-1:0] SEC_MAX = SEC_WIDTH'(6);
   localparam logic [CW-1:0]        LIMIT   = CW'(MISS_LIMIT);

   typedef enum logic [1:0] {S_WAIT, S_REQ, S_CHECK, S_READY} state_t;

   state_t               state, state_nxt;
   logic [TIM_WIDTH-1:0] cnt, cnt_nxt, per_lat, per_nxt;
   logic [TIM_WIDTH-1:0] cap_t1, cap_t1_nxt, cap_t2, cap_t2_nxt;
   logic [SEC_WIDTH-1:0] cap_sec, cap_sec_nxt;
   logic [TIM_WIDTH-1:0] shd_t1, shd_t1_nxt, shd_t2, shd_t2_nxt;
   logic [SEC_WIDTH-1:0] shd_sec, shd_sec_nxt;
   logic                 shd_vld, shd_vld_nxt;
   logic [TIM_WIDTH-1:0] t1_nxt, t2_nxt;
   logic [SEC_WIDTH-1:0] sec_nxt;
   logic                 upd_nxt, req_nxt, ps_nxt, fault_nxt;
   logic [7:0]           miss_nxt;
   logic [CW-1:0]        consec, consec_nxt;

   logic                 wrap, trig, sec_ok;
   logic [TIM_WIDTH-1:0] cl_t1, cl_t2, san_t2;
   logic [TIM_WIDTH:0]   sum;

   // Period counter decode; short periods trigger at the start of the period.
   assign wrap = (cnt >= per_lat);
   assign trig = (per_lat > LEAD) ? (cnt == (per_lat - LEAD)) : (cnt == '0);

   // Result sanitising on the captured values: clamp negatives, then limit T1+T2.
   assign cl_t1  = cap_t1[TIM_WIDTH-1] ? '0 : cap_t1;
   assign cl_t2  = cap_t2[TIM_WIDTH-1] ? '0 : cap_t2;
   assign sum    = {1'b0, cl_t1} + {1'b0, cl_t2};
   assign san_t2 = (sum > {1'b0, T_MAX}) ? (T_MAX - cl_t1) : cl_t2;
   assign sec_ok = (cap_sec >= SEC_MIN) && (cap_sec <= SEC_MAX);

   // Next-state and output logic; the wrap edge overrides every state.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = wrap ? '0 : cnt + TIM_WIDTH'(1);
      per_nxt     = wrap ? t_period_cnt : per_lat;
      cap_t1_nxt  = cap_t1;
      cap_t2_nxt  = cap_t2;
      cap_sec_nxt = cap_sec;
      shd_t1_nxt  = shd_t1;
      shd_t2_nxt  = shd_t2;
      shd_sec_nxt = shd_sec;
      shd_vld_nxt = shd_vld;
      t1_nxt      = t1_out;
      t2_nxt      = t2_out;
      sec_nxt     = sector_out;
      upd_nxt     = 1'b0;
      miss_nxt    = miss_cnt;
      consec_nxt  = consec;
      fault_nxt   = fault;

      if (wrap) begin
         state_nxt   = S_WAIT;
         shd_vld_nxt = 1'b0;
         if (!en || fault) begin
            t1_nxt = '0;
            t2_nxt = '0;
         end else if (shd_vld) begin
            t1_nxt     = shd_t1;
            t2_nxt     = shd_t2;
            sec_nxt    = shd_sec;
            upd_nxt    = 1'b1;
            consec_nxt = '0;
         end else begin
            if (miss_cnt != 8'hFF) miss_nxt = miss_cnt + 8'd1;
            if (consec != '1) consec_nxt = consec + CW'(1);
            if (consec_nxt == LIMIT) fault_nxt = 1'b1;
         end
      end else begin
         case (state)
            S_WAIT: begin
               if (trig && en && !fault) state_nxt = S_REQ;
            end
            S_REQ: begin
               if (calc_valid) begin
                  cap_t1_nxt  = t1_calc;
                  cap_t2_nxt  = t2_calc;
                  cap_sec_nxt = sector_calc;
                  state_nxt   = S_CHECK;
               end
            end
            S_CHECK: begin
               if (sec_ok) begin
                  shd_t1_nxt  = cl_t1;
                  shd_t2_nxt  = san_t2;
                  shd_sec_nxt = cap_sec;
                  shd_vld_nxt = 1'b1;
                  state_nxt   = S_READY;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_WAIT;
         endcase
      end

      if (!en) consec_nxt = '0;
      if (fault_clr) begin
         fault_nxt  = 1'b0;
         consec_nxt = '0;
      end

      req_nxt = (state_nxt == S_REQ);
      ps_nxt  = (cnt_nxt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_WAIT;
         cnt          <= '0;
         per_lat      <= '0;
         cap_t1       <= '0;
         cap_t2       <= '0;
         cap_sec      <= '0;
         shd_t1       <= '0;
         shd_t2       <= '0;
         shd_sec      <= SEC_MIN;
         shd_vld      <= 1'b0;
         t1_out       <= '0;
         t2_out       <= '0;
         sector_out   <= SEC_MIN;
         upd_done     <= 1'b0;
         miss_cnt     <= '0;
         consec       <= '0;
         fault        <= 1'b0;
         calc_req     <= 1'b0;
         period_start <= 1'b1;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         per_lat      <= per_nxt;
         cap_t1       <= cap_t1_nxt;
         cap_t2       <= cap_t2_nxt;
         cap_sec      <= cap_sec_nxt;
         shd_t1       <= shd_t1_nxt;
         shd_t2       <= shd_t2_nxt;
         shd_sec      <= shd_sec_nxt;
         shd_vld      <= shd_vld_nxt;
         t1_out       <= t1_nxt;
         t2_out       <= t2_nxt;
         sector_out   <= sec_nxt;
         upd_done     <= upd_nxt;
         miss_cnt     <= miss_nxt;
         consec       <= consec_nxt;
         fault        <= fault_nxt;
         calc_req     <= req_nxt;
         period_start <= ps_nxt;
      end
   end

endmodule
